// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx line to parallel bytes on a valid/ready port; error flag ports with UART_RX_ERR_FLAGS_EN.
// Latency: valid_o rises 1 clock after the final stop-bit sample.
// Backpressure: a frame that completes while valid_o is held is dropped and overrun_o pulses.
module uart_rx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    input  logic [3:0]           data_width_i,
    input  logic [1:0]           parity_i,
    input  logic [1:0]           stop_width_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
`ifdef UART_RX_ERR_FLAGS_EN
    output logic                 parity_err_o,
    output logic                 frame_err_o,
`endif
    output logic                 overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [DIV_WIDTH-1:0] cnt_q, div_q, cfg_div;
    logic [2:0]           bit_idx_q, last_idx_q, cfg_last_idx;
    logic                 stop_idx_q, two_stop_q, par_en_q, par_odd_q;
    logic [7:0]           shift_q;
    logic                 par_err_q, frm_err_q;
    logic                 start_det, bit_tick, par_bad, frm_bad_final;
    logic                 last_stop, frame_ok, done_ok, can_load;

    always_comb begin
        cfg_div = (clk_div_i < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : clk_div_i;
        if (data_width_i < 4'd5)
            cfg_last_idx = 3'd4;
        else if (data_width_i > 4'd8)
            cfg_last_idx = 3'd7;
        else
            cfg_last_idx = 3'(data_width_i - 4'd1);
    end

    assign start_det     = (state_q == S_IDLE) && rx_prev && !rx_sync;
    assign bit_tick      = (state_q != S_IDLE) && (cnt_q == '0);
    // Odd parity wants an odd total, so a zero XOR is the error case.
    assign par_bad       = (^{shift_q, rx_sync}) ^ par_odd_q;
    assign frm_bad_final = frm_err_q | ~rx_sync;
    assign last_stop     = (state_q == S_STOP) && bit_tick && (stop_idx_q == two_stop_q);
`ifdef UART_RX_ERR_FLAGS_EN
    assign frame_ok      = 1'b1;
`else
    assign frame_ok      = !(par_err_q || frm_bad_final);
`endif
    assign done_ok       = last_stop && frame_ok;
    assign can_load      = !valid_o || ready_i;
    assign busy_o        = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_det) state_d = S_START;
            S_START:  if (bit_tick) state_d = rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (bit_tick && (bit_idx_q == last_idx_q))
                          state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (bit_tick) state_d = S_STOP;
            S_STOP:   if (last_stop) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            cnt_q      <= '0;
            div_q      <= DIV_WIDTH'(4);
            bit_idx_q  <= '0;
            last_idx_q <= 3'd7;
            stop_idx_q <= 1'b0;
            two_stop_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            overrun_o  <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
`endif
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            state_q <= state_d;

            // Configuration is frozen at start detect for the whole frame.
            if (start_det) begin
                cnt_q      <= cfg_div >> 1;
                div_q      <= cfg_div;
                last_idx_q <= cfg_last_idx;
                par_en_q   <= (parity_i == 2'd1) || (parity_i == 2'd2);
                par_odd_q  <= (parity_i == 2'd1);
                two_stop_q <= stop_width_i[1];
                shift_q    <= '0;
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
                par_err_q  <= 1'b0;
                frm_err_q  <= 1'b0;
            end else if (state_q != S_IDLE) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - DIV_WIDTH'(1);
                end else begin
                    cnt_q <= div_q - DIV_WIDTH'(1);
                    case (state_q)
                        S_DATA: begin
                            shift_q[bit_idx_q] <= rx_sync;
                            bit_idx_q          <= bit_idx_q + 3'd1;
                        end
                        S_PARITY: par_err_q <= par_bad;
                        S_STOP: begin
                            frm_err_q  <= frm_bad_final;
                            stop_idx_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            overrun_o <= 1'b0;
            if (done_ok && can_load) begin
                data_o  <= shift_q;
                valid_o <= 1'b1;
`ifdef UART_RX_ERR_FLAGS_EN
                parity_err_o <= par_err_q;
                frame_err_o  <= frm_bad_final;
`endif
            end else begin
                if (done_ok)
                    overrun_o <= 1'b1;
                if (valid_o && ready_i)
                    valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx;
    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i, rx_i, ready_i;
    logic [DW-1:0] clk_div_i;
    logic [3:0]    data_width_i;
    logic [1:0]    parity_i, stop_width_i;
    logic [7:0]    data_o;
    logic          valid_o, busy_o, overrun_o;
    logic          pe_w, fe_w;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            ovr_cnt = 0;
    int            first_valid_cyc = -1;
    int            start_cyc = 0;
    logic [9:0]    rcv_q[$];

`ifdef UART_RX_ERR_FLAGS_EN
    logic parity_err_o, frame_err_o;
    assign pe_w = parity_err_o;
    assign fe_w = frame_err_o;
`else
    assign pe_w = 1'b0;
    assign fe_w = 1'b0;
`endif

    uart_rx #(.DIV_WIDTH(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .clk_div_i    (clk_div_i),
        .data_width_i (data_width_i),
        .parity_i     (parity_i),
        .stop_width_i (stop_width_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
`ifdef UART_RX_ERR_FLAGS_EN
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
`endif
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Inputs change 2ns after the rising edge, so the falling edge sees settled handshakes.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_o && ready_i) rcv_q.push_back({pe_w, fe_w, data_o});
            if (overrun_o) ovr_cnt++;
            if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    function automatic int eff_div(input logic [DW-1:0] d);
        return (d < 4) ? 4 : int'(d);
    endfunction

    function automatic int eff_w(input logic [3:0] w);
        return (w < 5) ? 5 : ((w > 8) ? 8 : int'(w));
    endfunction

    task automatic set_cfg(input int div, input int w, input int par, input int sw);
        clk_div_i    = DW'(div);
        data_width_i = 4'(w);
        parity_i     = 2'(par);
        stop_width_i = 2'(sw);
    endtask

    // Frame-level model: which word the consumer should see for this frame, if any.
    function automatic logic [9:0] model_word(input logic [7:0] d, input bit bad_par,
                                              input bit bad_stop, output bit deliver);
        int         w   = eff_w(data_width_i);
        bit         pen = (parity_i == 2'd1) || (parity_i == 2'd2);
        logic [7:0] m   = d & 8'((1 << w) - 1);
        bit         pf  = pen && bad_par;
        bit         ff  = bad_stop;
`ifdef UART_RX_ERR_FLAGS_EN
        deliver = 1'b1;
        return {pf, ff, m};
`else
        deliver = !(pf || ff);
        return {2'b00, m};
`endif
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        int         div   = eff_div(clk_div_i);
        int         w     = eff_w(data_width_i);
        int         stops = (stop_width_i >= 2) ? 2 : 1;
        bit         pen   = (parity_i == 2'd1) || (parity_i == 2'd2);
        logic [7:0] m     = d & 8'((1 << w) - 1);
        logic       p;
        start_cyc = cyc;
        rx_i = 1'b0;
        cycles(div);
        for (int i = 0; i < w; i++) begin
            rx_i = m[i];
            cycles(div);
        end
        if (pen) begin
            p = (($countones(m) % 2) == 1) ^ (parity_i == 2'd1);
            rx_i = p ^ bad_par;
            cycles(div);
        end
        for (int s = 0; s < stops; s++) begin
            rx_i = !(bad_stop && s == stops - 1);
            cycles(div);
        end
        rx_i = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 2000) begin
            step();
            n++;
        end
        if (busy_o) begin
            errors++;
            $display("FAIL wait_idle: busy_o=%b after %0d cycles, required 0", busy_o, n);
        end
        cycles(3);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; rx_i = 1'b1; ready_i = 1'b1;
        set_cfg(16, 8, 0, 1);
        cycles(3);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: data_o=%h required 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: valid_o=%b required 0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: busy_o=%b required 0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: overrun_o=%b required 0", overrun_o); end
        rst_i = 1'b0;
        cycles(4);
    endtask

    task automatic test_8n1();
        int lat, nom;
        set_cfg(16, 8, 0, 1);
        rcv_q.delete(); ovr_cnt = 0; first_valid_cyc = -1;
        send_frame(8'hA5, 0, 0);
        wait_idle();
        checks++;
        if (rcv_q.size() != 1 || rcv_q[0] !== 10'h0A5) begin
            errors++;
            $display("FAIL 8n1_data: got %0d words first=%h, required 1 word 0A5",
                     rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : 10'h3FF);
        end
        checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL 8n1_overrun: pulses=%0d required 0", ovr_cnt); end
        lat = first_valid_cyc - start_cyc;
        nom = 8 + 9 * 16;
        checks++;
        if (lat < nom + 1 || lat > nom + 5) begin
            errors++;
            $display("FAIL 8n1_latency: %0d clocks, required %0d..%0d", lat, nom + 1, nom + 5);
        end
    endtask

    task automatic test_parity_8e1();
        logic [9:0] exp;
        bit         dlv;
        set_cfg(16, 8, 2, 1);
        for (int k = 0; k < 2; k++) begin
            rcv_q.delete();
            exp = model_word(8'h07, k == 1, 0, dlv);
            send_frame(8'h07, k == 1, 0);
            wait_idle();
            checks++;
            if (dlv ? (rcv_q.size() != 1 || rcv_q[0] !== exp) : (rcv_q.size() != 0)) begin
                errors++;
                $display("FAIL 8e1_case%0d: got %0d words first=%h, required %0d words %h",
                         k, rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : 10'h3FF, dlv, exp);
            end
        end
    endtask

    task automatic test_7o2();
        logic [9:0] exp;
        bit         dlv;
        set_cfg(16, 7, 1, 2);
        for (int k = 0; k < 2; k++) begin
            rcv_q.delete();
            exp = model_word(8'h55, 0, k == 1, dlv);
            send_frame(8'h55, 0, k == 1);
            wait_idle();
            checks++;
            if (dlv ? (rcv_q.size() != 1 || rcv_q[0] !== exp) : (rcv_q.size() != 0)) begin
                errors++;
                $display("FAIL 7o2_case%0d: got %0d words first=%h, required %0d words %h",
                         k, rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : 10'h3FF, dlv, exp);
            end
        end
    endtask

    task automatic test_glitch();
        set_cfg(16, 8, 0, 1);
        rcv_q.delete();
        rx_i = 1'b0;
        cycles(4);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: busy_o=%b required 1", busy_o); end
        rx_i = 1'b1;
        cycles(40);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: busy_o=%b required 0", busy_o); end
        checks++;
        if (rcv_q.size() != 0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch_output: words=%0d valid_o=%b, required 0 words and valid 0", rcv_q.size(), valid_o);
        end
    endtask

    task automatic test_overrun();
        set_cfg(16, 8, 0, 1);
        rcv_q.delete(); ovr_cnt = 0;
        ready_i = 1'b0;
        send_frame(8'h11, 0, 0);
        cycles(5);
        send_frame(8'h22, 0, 0);
        wait_idle();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h11) begin
            errors++;
            $display("FAIL overrun_hold: valid_o=%b data_o=%h, required 1 and 11", valid_o, data_o);
        end
        checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL overrun_pulses: got %0d required 1", ovr_cnt); end
        ready_i = 1'b1;
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL overrun_drain_valid: valid_o=%b required 0", valid_o); end
        checks++;
        if (rcv_q.size() != 1 || rcv_q[0] !== 10'h011) begin
            errors++;
            $display("FAIL overrun_drain_data: got %0d words first=%h, required 1 word 011",
                     rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : 10'h3FF);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'h3C;
        set_cfg(16, 8, 0, 1);
        rcv_q.delete();
        rx_i = 1'b0;
        cycles(16);
        for (int i = 0; i < 3; i++) begin
            rx_i = d[i];
            cycles(16);
        end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: busy_o=%b required 1", busy_o); end
        rst_i = 1'b1;
        step();
        checks++;
        if (data_o !== 8'h00 || valid_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: data=%h valid=%b busy=%b ovr=%b, required 00 0 0 0",
                     data_o, valid_o, busy_o, overrun_o);
        end
        rx_i = 1'b1;
        cycles(3);
        rst_i = 1'b0;
        cycles(4);
        send_frame(8'h96, 0, 0);
        wait_idle();
        checks++;
        if (rcv_q.size() != 1 || rcv_q[0] !== 10'h096) begin
            errors++;
            $display("FAIL midreset_next: got %0d words first=%h, required 1 word 096",
                     rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : 10'h3FF);
        end
    endtask

    task automatic test_random();
        logic [9:0] exp;
        logic [7:0] d;
        bit         dlv, bp, bs;
        ovr_cnt = 0;
        ready_i = 1'b1;
        for (int n = 0; n < 24; n++) begin
            set_cfg($urandom_range(0, 20), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 3) == 0);
            rcv_q.delete();
            exp = model_word(d, bp, bs, dlv);
            send_frame(d, bp, bs);
            wait_idle();
            checks++;
            if (dlv ? (rcv_q.size() != 1 || rcv_q[0] !== exp) : (rcv_q.size() != 0)) begin
                errors++;
                $display("FAIL random_%0d: div=%0d w=%0d par=%0d sw=%0d got %0d words first=%h, required %0d words %h",
                         n, clk_div_i, data_width_i, parity_i, stop_width_i, rcv_q.size(),
                         (rcv_q.size() > 0) ? rcv_q[0] : 10'h3FF, dlv, exp);
            end
        end
        checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL random_overrun: pulses=%0d required 0", ovr_cnt); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_8e1();
        test_7o2();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
